// File: rtl/mul4_eval_pkg.sv
// ---------------------------------------------------------------------------
// mul4_eval_pkg
// Shared definitions for the 2x2-bit vector multiplier evaluator:
//   - state_e        : evaluator FSM states
//   - ROUND0_*       : round-0 exhaustive stimulus (lane i carries operand index i)
//   - GOLD0_*        : round-0 golden product bits y3..y0
//   - ror16()        : rotate-right used to derive round r stimulus/golden
// ---------------------------------------------------------------------------
package mul4_eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SCORE,
    DONE
  } state_e;

  // Lane i of round 0 encodes idx=i as {a1,a0,b1,b0}.
  localparam logic [15:0] ROUND0_A1 = 16'hFF00;
  localparam logic [15:0] ROUND0_A0 = 16'hF0F0;
  localparam logic [15:0] ROUND0_B1 = 16'hCCCC;
  localparam logic [15:0] ROUND0_B0 = 16'hAAAA;

  // Bit k of a*b for each lane of round 0.
  localparam logic [15:0] GOLD0_Y3 = 16'h8000;
  localparam logic [15:0] GOLD0_Y2 = 16'h4C00;
  localparam logic [15:0] GOLD0_Y1 = 16'h6AC0;
  localparam logic [15:0] GOLD0_Y0 = 16'hA0A0;

  // Result bit i = vec bit (i+r)%16.
  function automatic logic [15:0] ror16(input logic [15:0] vec, input logic [3:0] r);
    logic [31:0] dbl;
    dbl = {vec, vec} >> r;
    return dbl[15:0];
  endfunction

endpackage

// File: rtl/popcount64.sv
// ---------------------------------------------------------------------------
// popcount64
// Combinational population count of a 64-bit vector.
// Ports:
//   vec   in  64  vector to count
//   count out 7   number of ones in vec (0..64)
// ---------------------------------------------------------------------------
module popcount64 (
  input  logic [63:0] vec,
  output logic [6:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + 7'(vec[i]);
    end
  end

endmodule

// File: rtl/mul4_vector_evaluator.sv
// ---------------------------------------------------------------------------
// mul4_vector_evaluator
// Scores a bit-sliced 2x2-bit multiplier candidate. Each round presents one
// exhaustive 16-lane vector (rotated by the round number), captures the
// candidate's y3..y0 vectors and accumulates the number of bits that agree
// with the golden product. A round that gets no response within TIMEOUT
// cycles aborts the evaluation.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin an evaluation (accepted only in IDLE)
//   busy                     evaluation in progress
//   done                     one-cycle completion pulse
//   score / perfect / timeout  result, valid with done and held afterwards
//   cand_a1/a0/b1/b0, cand_valid, cand_ready   stimulus handshake to candidate
//   rsp_y3/y2/y1/y0, rsp_valid                 candidate response
// ---------------------------------------------------------------------------
module mul4_vector_evaluator
  import mul4_eval_pkg::*;
#(
  parameter int NUM_ROUNDS = 4,
  parameter int TIMEOUT    = 15,
  parameter int SCORE_W    = $clog2(64 * NUM_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic               timeout,
  output logic [15:0]        cand_a1,
  output logic [15:0]        cand_a0,
  output logic [15:0]        cand_b1,
  output logic [15:0]        cand_b0,
  output logic               cand_valid,
  input  logic               cand_ready,
  input  logic [15:0]        rsp_y3,
  input  logic [15:0]        rsp_y2,
  input  logic [15:0]        rsp_y1,
  input  logic [15:0]        rsp_y0,
  input  logic               rsp_valid
);

  localparam int                 TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE  = SCORE_W'(64 * NUM_ROUNDS);

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [63:0]        rsp_q, rsp_d;       // {y3, y2, y1, y0}
  logic [63:0]        vec_q, vec_d;       // {a1, a0, b1, b0}
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perfect_q, perfect_d;
  logic               timeout_q, timeout_d;
  logic               cand_valid_q, cand_valid_d;

  logic [63:0]        gold_vec;
  logic [6:0]         match_cnt;

  assign gold_vec = {ror16(GOLD0_Y3, round_q), ror16(GOLD0_Y2, round_q),
                     ror16(GOLD0_Y1, round_q), ror16(GOLD0_Y0, round_q)};

  // Matching bits are the zeros of the XOR, i.e. the ones of its inverse.
  popcount64 u_popcount (
    .vec   (~(rsp_q ^ gold_vec)),
    .count (match_cnt)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave one unassigned (no latches).
    state_d   = state_q;
    round_d   = round_q;
    tmo_d     = tmo_q;
    rsp_d     = rsp_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    score_d   = score_q;
    perfect_d = perfect_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          round_d   = '0;
          acc_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ISSUE: begin
        if (cand_valid_q && cand_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          rsp_d   = {rsp_y3, rsp_y2, rsp_y1, rsp_y0};
          state_d = SCORE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SCORE: begin
        acc_d = acc_q + SCORE_W'(match_cnt);
        if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    busy_d       = (state_d inside {ISSUE, WAIT, SCORE});
    done_d       = (state_d == DONE);
    cand_valid_d = (state_d == ISSUE);

    // Stimulus depends only on the round, so it stays stable while ISSUE
    // waits for cand_ready.
    if (state_d == ISSUE) begin
      vec_d = {ror16(ROUND0_A1, round_d), ror16(ROUND0_A0, round_d),
               ror16(ROUND0_B1, round_d), ror16(ROUND0_B0, round_d)};
    end

    if (state_d == DONE) begin
      score_d   = acc_d;
      perfect_d = !timeout_d && (acc_d == MAX_SCORE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      round_q      <= '0;
      tmo_q        <= '0;
      // NOTE: the response capture register is reset as well, so no state
      // survives a mid-run reset and simulation never starts from X.
      rsp_q        <= '0;
      vec_q        <= '0;
      acc_q        <= '0;
      score_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      perfect_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cand_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      round_q      <= round_d;
      tmo_q        <= tmo_d;
      rsp_q        <= rsp_d;
      vec_q        <= vec_d;
      acc_q        <= acc_d;
      score_q      <= score_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      perfect_q    <= perfect_d;
      timeout_q    <= timeout_d;
      cand_valid_q <= cand_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign score      = score_q;
  assign perfect    = perfect_q;
  assign timeout    = timeout_q;
  assign cand_valid = cand_valid_q;
  assign {cand_a1, cand_a0, cand_b1, cand_b0} = vec_q;

endmodule

// File: tb/tb_mul4_vector_evaluator.sv
// ---------------------------------------------------------------------------
// tb_mul4_vector_evaluator
// Drives mul4_vector_evaluator with a modelled candidate. The expected
// result of each evaluation is computed from lane arithmetic (idx, a*b)
// and queued at start; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_mul4_vector_evaluator;

  localparam int NUM_ROUNDS = 4;
  localparam int TIMEOUT    = 15;
  localparam int SCORE_W    = $clog2(64 * NUM_ROUNDS + 1);
  localparam int MAX_SCORE  = 64 * NUM_ROUNDS;

  typedef struct {
    int score;
    bit perfect;
    bit timeout;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic [SCORE_W-1:0] score;
  logic               perfect;
  logic               timeout;
  logic [15:0]        cand_a1, cand_a0, cand_b1, cand_b0;
  logic               cand_valid;
  logic               cand_ready;
  logic [15:0]        rsp_y3, rsp_y2, rsp_y1, rsp_y0;
  logic               rsp_valid;

  mul4_vector_evaluator #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .TIMEOUT    (TIMEOUT),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .perfect    (perfect),
    .timeout    (timeout),
    .cand_a1    (cand_a1),
    .cand_a0    (cand_a0),
    .cand_b1    (cand_b1),
    .cand_b0    (cand_b0),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .rsp_y3     (rsp_y3),
    .rsp_y2     (rsp_y2),
    .rsp_y1     (rsp_y1),
    .rsp_y0     (rsp_y0),
    .rsp_valid  (rsp_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // which: 0=a1 1=a0 2=b1 3=b0
  function automatic logic [15:0] model_stim(input int r, input int which);
    logic [15:0] v;
    int idx, a, b;
    for (int i = 0; i < 16; i++) begin
      idx = (i + r) % 16;
      a   = idx / 4;
      b   = idx % 4;
      case (which)
        0:       v[i] = 1'((a / 2) % 2);
        1:       v[i] = 1'(a % 2);
        2:       v[i] = 1'((b / 2) % 2);
        default: v[i] = 1'(b % 2);
      endcase
    end
    return v;
  endfunction

  function automatic logic [15:0] model_gold(input int r, input int k);
    logic [15:0] v;
    int idx, p;
    for (int i = 0; i < 16; i++) begin
      idx  = (i + r) % 16;
      p    = (idx / 4) * (idx % 4);
      v[i] = 1'((p >> k) % 2);
    end
    return v;
  endfunction

  // Response the modelled candidate will return: resp_tab[round][k] = y_k.
  logic [15:0] resp_tab [NUM_ROUNDS][4];
  int silent_round = -1;   // round in which the candidate never answers
  int stall_round  = -1;   // round in which cand_ready is held low
  int stall_left   = 0;
  int junk_left    = 0;    // garbage rsp_valid pulses while idle
  bit hs_junk      = 1'b0; // garbage rsp_valid in the handshake cycle

  // mode 0: correct product, 1: all zeros, else: product with random bit errors
  task automatic fill(input int mode);
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      for (int k = 0; k < 4; k++) begin
        case (mode)
          0:       resp_tab[r][k] = model_gold(r, k);
          1:       resp_tab[r][k] = 16'h0000;
          default: resp_tab[r][k] = model_gold(r, k) ^ 16'($urandom & $urandom);
        endcase
      end
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    logic [15:0] g;
    e.score   = 0;
    e.timeout = 1'b0;
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      if (r == silent_round) begin
        e.timeout = 1'b1;
        break;
      end
      for (int k = 0; k < 4; k++) begin
        g = model_gold(r, k);
        for (int i = 0; i < 16; i++) begin
          if (resp_tab[r][k][i] == g[i]) e.score++;
        end
      end
    end
    e.perfect = !e.timeout && (e.score == MAX_SCORE);
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t sb[$];
  int   done_count    = 0;
  int   last_done_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_count++;
        last_done_cyc = cyc;
        check("done_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("score",   64'(score),   64'(e.score));
          check("perfect", 64'(perfect), 64'(e.perfect));
          check("timeout", 64'(timeout), 64'(e.timeout));
        end
      end
    end
  end

  // ---------------- candidate responder ----------------
  int rr      = 0;      // rounds handshaken in the current evaluation
  bit pending = 1'b0;
  int pend_r  = 0;
  int hs_cyc  = 0;

  initial begin
    rsp_valid  = 1'b0;
    cand_ready = 1'b1;
    {rsp_y3, rsp_y2, rsp_y1, rsp_y0} = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (pending) begin
        pending   = 1'b0;
        rsp_valid = 1'b1;
        if (pend_r < NUM_ROUNDS) begin
          rsp_y3 = resp_tab[pend_r][3];
          rsp_y2 = resp_tab[pend_r][2];
          rsp_y1 = resp_tab[pend_r][1];
          rsp_y0 = resp_tab[pend_r][0];
        end
      end else if (junk_left > 0) begin
        junk_left--;
        rsp_valid = 1'b1;
        {rsp_y3, rsp_y2, rsp_y1, rsp_y0} = {$urandom, $urandom};
      end

      if (cand_valid === 1'b1) begin
        if (rr == stall_round && stall_left > 0) begin
          stall_left--;
          cand_ready = 1'b0;
          check("stall_busy", 64'(busy),    64'd1);
          check("stall_a1",   64'(cand_a1), 64'(model_stim(rr, 0)));
          check("stall_a0",   64'(cand_a0), 64'(model_stim(rr, 1)));
          check("stall_b1",   64'(cand_b1), 64'(model_stim(rr, 2)));
          check("stall_b0",   64'(cand_b0), 64'(model_stim(rr, 3)));
        end else begin
          cand_ready = 1'b1;
          check("stim_a1", 64'(cand_a1), 64'(model_stim(rr, 0)));
          check("stim_a0", 64'(cand_a0), 64'(model_stim(rr, 1)));
          check("stim_b1", 64'(cand_b1), 64'(model_stim(rr, 2)));
          check("stim_b0", 64'(cand_b0), 64'(model_stim(rr, 3)));
          hs_cyc = cyc;
          if (hs_junk) begin
            rsp_valid = 1'b1;
            {rsp_y3, rsp_y2, rsp_y1, rsp_y0} = {$urandom, $urandom};
          end
          if (rr != silent_round) begin
            pending = 1'b1;
            pend_r  = rr;
          end
          rr++;
        end
      end else begin
        cand_ready = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  // spam: hold start high through the run, then pulse it in the DONE cycle.
  task automatic run_eval(input bit spam);
    exp_t e;
    int   n0;
    int   c;
    repeat (2) @(negedge clk);
    #1;
    e = model_expect();
    sb.push_back(e);
    n0      = done_count;
    rr      = 0;
    pending = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (c = 0; c < 200 && done_count == n0; c++) begin
      start = spam && (c < 8);
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    check("done_seen", 64'(done_count - n0), 64'd1);
    if (done_count == n0) sb.delete();
    if (spam) begin
      start = 1'b1;              // this is the DONE cycle
      @(negedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("start_in_done_ignored_busy", 64'(busy), 64'd0);
      check("start_in_done_ignored_done", 64'(done_count - n0), 64'd1);
    end
  endtask

  initial begin
    int n0;
    int c;
    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_cand_valid", 64'(cand_valid), 64'd0);
    check("rst_score",      64'(score),      64'd0);
    check("rst_perfect",    64'(perfect),    64'd0);
    check("rst_timeout",    64'(timeout),    64'd0);
    check("rst_vectors",    {cand_a1, cand_a0, cand_b1, cand_b0}, 64'd0);
    #1;
    rst = 1'b0;

    // 1) perfect candidate
    fill(0);
    run_eval(1'b0);

    // 2) all-zero responder
    fill(1);
    run_eval(1'b0);

    // 3) silent in round 2
    fill(0);
    silent_round = 2;
    run_eval(1'b0);
    check("timeout_latency", 64'(last_done_cyc - hs_cyc), 64'(TIMEOUT + 1));
    silent_round = -1;

    // 4) backpressure in round 1
    stall_round = 1;
    stall_left  = 5;
    run_eval(1'b0);
    check("stall_consumed", 64'(stall_left), 64'd0);
    stall_round = -1;

    // 5) stray rsp_valid while idle and at handshake, start while busy / in DONE
    junk_left = 3;
    repeat (4) @(negedge clk);
    #1;
    hs_junk = 1'b1;
    run_eval(1'b1);
    hs_junk = 1'b0;

    // 6) reset in WAIT of round 1
    fill(0);
    silent_round = 1;
    repeat (2) @(negedge clk);
    #1;
    sb.push_back(model_expect());
    n0      = done_count;
    rr      = 0;
    pending = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (c = 0; c < 100 && rr < 2; c++) begin
      @(negedge clk);
      #1;
    end
    check("reached_round1", 64'(rr), 64'd2);
    @(negedge clk);
    #1;
    check("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    check("midrst_busy",       64'(busy),       64'd0);
    check("midrst_cand_valid", 64'(cand_valid), 64'd0);
    check("midrst_score",      64'(score),      64'd0);
    check("midrst_done",       64'(done),       64'd0);
    check("midrst_timeout",    64'(timeout),    64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("no_done_after_rst", 64'(done_count - n0), 64'd0);
    silent_round = -1;
    pending      = 1'b0;
    run_eval(1'b0);

    // randomized candidates
    for (int t = 0; t < 8; t++) begin
      fill(2);
      silent_round = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_ROUNDS - 1)) : -1;
      stall_round  = int'($urandom_range(0, NUM_ROUNDS - 1));
      stall_left   = int'($urandom_range(0, 3));
      hs_junk      = 1'($urandom_range(0, 1));
      run_eval(1'b0);
    end
    silent_round = -1;
    stall_round  = -1;
    hs_junk      = 1'b0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
